// File: rtl/ikun_binary_pattern_gen.sv
// Deterministic 1-bit AXI4-Stream test-frame source with SOF/EOL framing and tready
// back-pressure, used to drive the morphology filters when the camera front end is bypassed.
module ikun_binary_pattern_gen #(
  parameter int AW        = 11,
  parameter int DW        = 1,
  parameter int COLS      = 1280,
  parameter int ROWS      = 720,
  parameter int HBLANK    = 16,
  parameter int VBLANK    = 64,
  parameter int CHK_SHIFT = 3,
  parameter int BOX_W     = 32,
  parameter int BOX_H     = 32,
  parameter int BOX_Y     = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [2:0]    pattern_sel,
  output logic [DW-1:0] m_axis_video_tdata,
  output logic          m_axis_video_tvalid,
  input  logic          m_axis_video_tready,
  output logic          m_axis_video_tlast,
  output logic          m_axis_video_tuser,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLK, VBLK} state_t;

  localparam int BW = 16;
  localparam logic [AW-1:0] X_LAST   = AW'(COLS - 1);
  localparam logic [AW-1:0] Y_LAST   = AW'(ROWS - 1);
  localparam logic [BW-1:0] HB_LAST  = (HBLANK > 0) ? BW'(HBLANK - 1) : '0;
  localparam logic [BW-1:0] VB_LAST  = (VBLANK > 0) ? BW'(VBLANK - 1) : '0;
  localparam logic [AW:0]   BOX_W_C  = (AW+1)'(BOX_W);
  localparam logic [AW:0]   BOX_Y_LO = (AW+1)'(BOX_Y);
  localparam logic [AW:0]   BOX_Y_HI = (AW+1)'(BOX_Y + BOX_H);

  state_t        state_q, state_d;
  logic [AW-1:0] x_q, x_d, y_q, y_d, box_x_q, box_x_d;
  logic [2:0]    pat_q, pat_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0] tdata_q;
  logic          tvalid_q, tlast_q, tuser_q, busy_q;
  logic          beat, frame_start;

  assign beat = tvalid_q & m_axis_video_tready;

  // Extra MSB on the box compare keeps box_x + BOX_W from wrapping, so the box clips.
  function automatic logic pixel_value(input logic [2:0] pat, input logic [AW-1:0] x,
                                       input logic [AW-1:0] y, input logic [AW-1:0] bx);
    logic [AW:0] xe, ye, be;
    logic        pix;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    be  = {1'b0, bx};
    pix = 1'b0;
    case (pat)
      3'd1: pix = 1'b1;
      3'd2: pix = x[CHK_SHIFT] ^ y[CHK_SHIFT];
      3'd3: pix = (x[2:0] == 3'd0) && (y[2:0] == 3'd0);
      3'd4: pix = (xe >= be) && (xe < be + BOX_W_C) && (ye >= BOX_Y_LO) && (ye < BOX_Y_HI);
      3'd5: pix = x[CHK_SHIFT];
      default: pix = 1'b0;
    endcase
    return pix;
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pat_d       = pat_q;
    box_x_d     = box_x_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          pat_d   = pattern_sel;
          x_d     = '0;
          y_d     = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (beat) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d         = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              if (VBLANK == 0) begin
                frame_start = 1'b1;
              end else begin
                state_d = VBLK;
                blank_d = '0;
              end
            end else begin
              y_d = y_q + AW'(1);
              if (HBLANK != 0) begin
                state_d = HBLK;
                blank_d = '0;
              end
            end
          end else begin
            x_d = x_q + AW'(1);
          end
        end
      end
      HBLK: begin
        if (blank_q == HB_LAST) state_d = ACTIVE;
        else                    blank_d = blank_q + BW'(1);
      end
      VBLK: begin
        if (blank_q == VB_LAST) frame_start = 1'b1;
        else                    blank_d = blank_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase

    // enable is only honoured here; a running frame always finishes.
    if (frame_start) begin
      if (enable) begin
        pat_d   = pattern_sel;
        box_x_d = (box_x_q == X_LAST) ? '0 : box_x_q + AW'(1);
        state_d = ACTIVE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Outputs are registered from next-state values, so a stall simply re-registers the same beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      box_x_q     <= '0;
      pat_q       <= 3'd0;
      blank_q     <= '0;
      frame_cnt_q <= 16'd0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      box_x_q     <= box_x_d;
      pat_q       <= pat_d;
      blank_q     <= blank_d;
      frame_cnt_q <= frame_cnt_d;
      tdata_q     <= (state_d == ACTIVE) ? {DW{pixel_value(pat_d, x_d, y_d, box_x_d)}} : '0;
      tvalid_q    <= (state_d == ACTIVE);
      tlast_q     <= (state_d == ACTIVE) && (x_d == X_LAST);
      tuser_q     <= (state_d == ACTIVE) && (x_d == '0) && (y_d == '0);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign m_axis_video_tdata  = tdata_q;
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tlast  = tlast_q;
  assign m_axis_video_tuser  = tuser_q;
  assign frame_cnt           = frame_cnt_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_ikun_binary_pattern_gen.sv
// Directed bench for ikun_binary_pattern_gen on an 8x4 frame with HBLANK=2, VBLANK=3.
module tb_ikun_binary_pattern_gen;
  localparam int NB = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  pattern_sel = 3'd0;
  logic [0:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
  logic [15:0] frame_cnt;
  logic        busy;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] cap_data, cap_last, cap_user;
  int          cap_cyc[NB];
  int          cap_n;
  bit          cap_timeout;
  int          hold_err;
  int          stall_cnt;
  logic [7:0]  lfsr = 8'hA5;
  logic [15:0] exp_frames = 16'd0;

  always #5 clk = ~clk;

  ikun_binary_pattern_gen #(
    .AW(11), .DW(1), .COLS(8), .ROWS(4), .HBLANK(2), .VBLANK(3),
    .CHK_SHIFT(1), .BOX_W(3), .BOX_H(1), .BOX_Y(1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .pattern_sel         (pattern_sel),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tlast  (tlast),
    .m_axis_video_tuser  (tuser),
    .frame_cnt           (frame_cnt),
    .busy                (busy)
  );

  // Collects nb accepted beats (bit n = beat n); optionally stalls with an LFSR,
  // drops enable after beat drop_at and changes pattern_sel after beat sel_at.
  task automatic capture(input int nb, input bit use_lfsr, input int drop_at,
                         input int sel_at, input logic [2:0] sel_val);
    int   cyc;
    bit   prev_stall;
    logic pd, pl, pu;
    cap_data = '0; cap_last = '0; cap_user = '0;
    cap_n = 0; cap_timeout = 0; hold_err = 0; stall_cnt = 0;
    cyc = 0; prev_stall = 0; pd = 0; pl = 0; pu = 0;
    while (cap_n < nb && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      if (prev_stall && (tvalid !== 1'b1 || tdata[0] !== pd || tlast !== pl || tuser !== pu))
        hold_err++;
      if (use_lfsr) begin
        tready = lfsr[0];
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else begin
        tready = 1'b1;
      end
      if (tvalid === 1'b1 && tready) begin
        cap_data[cap_n] = tdata[0];
        cap_last[cap_n] = tlast;
        cap_user[cap_n] = tuser;
        cap_cyc[cap_n]  = cyc;
        if (cap_n == drop_at) enable = 1'b0;
        if (cap_n == sel_at) pattern_sel = sel_val;
        cap_n++;
      end
      prev_stall = (tvalid === 1'b1) && !tready;
      if (prev_stall) stall_cnt++;
      pd = tdata[0]; pl = tlast; pu = tuser;
    end
    if (cap_n < nb) cap_timeout = 1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({tdata, tvalid, tlast, tuser} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_axis: got %b expected 0000", {tdata, tvalid, tlast, tuser});
    end
    tests_run++;
    if (frame_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_no_enable: got busy=%b tvalid=%b expected 0/0", busy, tvalid);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_all_ones;
    bit ok;
    pattern_sel = 3'd1; enable = 1'b1;
    capture(NB, 0, 0, -1, 3'd0);
    tests_run++;
    if (cap_timeout) begin
      tests_failed++; $display("FAIL ones_timeout: got %0d beats expected 32", cap_n);
    end
    tests_run++;
    if (cap_data !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL ones_data: got %h expected ffffffff", cap_data);
    end
    tests_run++;
    if (cap_user !== 32'h0000_0001) begin
      tests_failed++; $display("FAIL ones_tuser: got %h expected 00000001", cap_user);
    end
    tests_run++;
    if (cap_last !== 32'h8080_8080) begin
      tests_failed++; $display("FAIL ones_tlast: got %h expected 80808080", cap_last);
    end
    tests_run++;
    if (cap_cyc[0] != 1) begin
      tests_failed++; $display("FAIL start_latency: got %0d expected 1", cap_cyc[0]);
    end
    tests_run++;
    if (cap_cyc[8] - cap_cyc[7] != 3) begin
      tests_failed++; $display("FAIL hblank_gap: got %0d expected 3", cap_cyc[8] - cap_cyc[7]);
    end
    tests_run++;
    if (cap_cyc[31] - cap_cyc[0] != 37) begin
      tests_failed++; $display("FAIL frame_span: got %0d expected 37", cap_cyc[31] - cap_cyc[0]);
    end
    @(posedge clk); #1;
    exp_frames++;
    tests_run++;
    if (frame_cnt !== exp_frames || tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ones_frame_cnt: got cnt=%0d tvalid=%b expected cnt=%0d tvalid=0", frame_cnt, tvalid, exp_frames);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL ones_idle: got busy=%b expected 0", busy);
    end
    $display("[TB] test_all_ones: %0d beats captured", cap_n);
  endtask

  task automatic test_checker(input bit use_lfsr);
    bit ok;
    pattern_sel = 3'd2; enable = 1'b1;
    capture(NB, use_lfsr, 0, -1, 3'd0);
    tready = 1'b1;
    tests_run++;
    if (cap_timeout || cap_data !== 32'h3333_CCCC) begin
      tests_failed++; $display("FAIL checker_data(stall=%0d): got %h n=%0d expected 3333cccc n=32", use_lfsr, cap_data, cap_n);
    end
    tests_run++;
    if (cap_user !== 32'h0000_0001 || cap_last !== 32'h8080_8080) begin
      tests_failed++; $display("FAIL checker_framing(stall=%0d): got user=%h last=%h expected 00000001/80808080", use_lfsr, cap_user, cap_last);
    end
    if (use_lfsr) begin
      tests_run++;
      if (hold_err != 0) begin
        tests_failed++; $display("FAIL stall_hold: got %0d violations expected 0", hold_err);
      end
      tests_run++;
      if (stall_cnt == 0) begin
        tests_failed++; $display("FAIL stall_seen: got %0d stall cycles expected >0", stall_cnt);
      end
    end
    wait_idle(ok);
    exp_frames++;
    tests_run++;
    if (!ok || frame_cnt !== exp_frames) begin
      tests_failed++; $display("FAIL checker_frame_cnt: got %0d idle=%0d expected %0d idle=1", frame_cnt, ok, exp_frames);
    end
    $display("[TB] test_checker stall=%0d: data=%h stalls=%0d", use_lfsr, cap_data, stall_cnt);
  endtask

  task automatic test_box;
    bit         ok;
    logic [7:0] line1;
    pattern_sel = 3'd4; enable = 1'b1;
    for (int f = 0; f < 9; f++) begin
      capture(NB, 0, (f == 8) ? 0 : -1, -1, 3'd0);
      line1 = 8'h07 << (f % 8);
      tests_run++;
      if (cap_timeout || cap_data !== {16'h0000, line1, 8'h00}) begin
        tests_failed++; $display("FAIL box_frame%0d: got %h expected %h", f, cap_data, {16'h0000, line1, 8'h00});
      end
      if (f > 0) begin
        tests_run++;
        if (cap_cyc[0] != 4) begin
          tests_failed++; $display("FAIL vblank_gap_frame%0d: got %0d expected 4", f, cap_cyc[0]);
        end
      end
      $display("[TB] test_box frame %0d: line1=%b (bit x=pixel x)", f, cap_data[15:8]);
    end
    wait_idle(ok);
    exp_frames += 16'd9;
    tests_run++;
    if (!ok || frame_cnt !== exp_frames) begin
      tests_failed++; $display("FAIL box_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_pattern_change;
    bit ok;
    pattern_sel = 3'd1; enable = 1'b1;
    capture(NB, 0, -1, 10, 3'd2);
    tests_run++;
    if (cap_timeout || cap_data !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL sel_change_cur: got %h expected ffffffff", cap_data);
    end
    capture(NB, 0, 0, -1, 3'd0);
    tests_run++;
    if (cap_timeout || cap_data !== 32'h3333_CCCC) begin
      tests_failed++; $display("FAIL sel_change_next: got %h expected 3333cccc", cap_data);
    end
    tests_run++;
    if (cap_user !== 32'h0000_0001) begin
      tests_failed++; $display("FAIL sel_change_tuser: got %h expected 00000001", cap_user);
    end
    wait_idle(ok);
    exp_frames += 16'd2;
    tests_run++;
    if (!ok || frame_cnt !== exp_frames) begin
      tests_failed++; $display("FAIL sel_change_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
    end
    $display("[TB] test_pattern_change: next frame data=%h", cap_data);
  endtask

  task automatic test_enable_drop;
    pattern_sel = 3'd5; enable = 1'b1;
    capture(NB, 0, 5, -1, 3'd0);
    tests_run++;
    if (cap_timeout || cap_data !== 32'hCCCC_CCCC) begin
      tests_failed++; $display("FAIL drop_frame: got %h n=%0d expected cccccccc n=32", cap_data, cap_n);
    end
    @(posedge clk); #1;
    exp_frames++;
    tests_run++;
    if (frame_cnt !== exp_frames || busy !== 1'b1) begin
      tests_failed++; $display("FAIL drop_vblk_entry: got cnt=%0d busy=%b expected cnt=%0d busy=1", frame_cnt, busy, exp_frames);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || tvalid !== 1'b0) begin
      tests_failed++; $display("FAIL drop_vblk_end: got busy=%b tvalid=%b expected 1/0", busy, tvalid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      tests_failed++; $display("FAIL drop_idle: got busy=%b tvalid=%b expected 0/0", busy, tvalid);
    end
    $display("[TB] test_enable_drop: data=%h", cap_data);
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    pattern_sel = 3'd3; enable = 1'b1;
    capture(18, 0, -1, -1, 3'd0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_outputs: got tvalid=%b tlast=%b busy=%b expected 0/0/0", tvalid, tlast, busy);
    end
    tests_run++;
    if (frame_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL midreset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    exp_frames = 16'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    capture(NB, 0, 0, -1, 3'd0);
    tests_run++;
    if (cap_timeout || cap_user !== 32'h0000_0001 || cap_cyc[0] != 1) begin
      tests_failed++; $display("FAIL restart_sof: got user=%h cyc=%0d expected 00000001 cyc=1", cap_user, cap_cyc[0]);
    end
    tests_run++;
    if (cap_data !== 32'h0000_0001 || frame_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL restart_dots: got %h cnt=%0d expected 00000001 cnt=0", cap_data, frame_cnt);
    end
    wait_idle(ok);
    exp_frames++;
    tests_run++;
    if (!ok || frame_cnt !== exp_frames) begin
      tests_failed++; $display("FAIL restart_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
    end
    $display("[TB] test_reset_mid_frame: restart data=%h", cap_data);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_checker(1'b0);
    test_checker(1'b1);
    test_box();
    test_pattern_change();
    test_enable_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
